// File: rtl/evt_pkg.sv
// Shared types and constants for the event burst generator.
package evt_pkg;

  localparam int unsigned COUNT_W_DEF = 16;
  localparam int unsigned GAP_W_DEF   = 8;

  // Smallest legal low gap between pulses; a programmed gap of 0 is raised to this.
  localparam int unsigned GAP_MIN = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    FIN   = 2'd3
  } evt_state_e;

endpackage

// File: rtl/evt_gap_timer.sv
// Loadable down-counter timing the low gap between pulses.
// tc_o is registered and is high while the count sits at GAP_MIN.
module evt_gap_timer
  import evt_pkg::*;
#(
  parameter int unsigned W = GAP_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tc_q;

  // Next count: load wins over decrement; decrement stops at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q > W'(GAP_MIN))) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count and terminal-count flag registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= (cnt_d == W'(GAP_MIN));
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/evt_burst_gen.sv
// Event-pulse burst source: emits num single-cycle pulses separated by
// max(gap,1) low cycles, with start/busy/done handshake and a sent count.
module evt_burst_gen
  import evt_pkg::*;
#(
  parameter int unsigned COUNT_W = COUNT_W_DEF,
  parameter int unsigned GAP_W   = GAP_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_in,
  input  logic [COUNT_W-1:0] num_in,
  input  logic [GAP_W-1:0]   gap_in,
  input  logic               abort_in,
  output logic               evt_out,
  output logic               busy_out,
  output logic               done_out,
  output logic [COUNT_W-1:0] sent_out
);

  evt_state_e         state_q;
  logic [COUNT_W-1:0] num_q;
  logic [GAP_W-1:0]   gap_q;
  logic [COUNT_W-1:0] sent_q;
  logic               evt_q;
  logic               busy_q;
  logic               done_q;

  logic [COUNT_W-1:0] sent_inc;
  logic               timer_load;
  logic               timer_dec;
  logic               timer_tc;

  assign sent_inc = sent_q + COUNT_W'(1);

  // Reloading in every PULSE cycle is harmless when the burst ends instead.
  assign timer_load = (state_q == PULSE);
  assign timer_dec  = (state_q == GAP);

  evt_gap_timer #(
    .W (GAP_W)
  ) u_gap_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (gap_q),
    .dec_i      (timer_dec),
    .tc_o       (timer_tc)
  );

  // Burst FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      gap_q   <= GAP_W'(GAP_MIN);
      sent_q  <= '0;
      evt_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      evt_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_in) begin
            num_q  <= num_in;
            gap_q  <= (gap_in == '0) ? GAP_W'(GAP_MIN) : gap_in;
            sent_q <= '0;
            if (num_in != '0) begin
              state_q <= PULSE;
              evt_q   <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end
        PULSE: begin
          // The pulse on evt_out this cycle is always counted, even on abort.
          sent_q <= sent_inc;
          if (abort_in || (sent_inc == num_q)) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else begin
            state_q <= GAP;
            busy_q  <= 1'b1;
          end
        end
        GAP: begin
          if (abort_in) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else if (timer_tc) begin
            state_q <= PULSE;
            evt_q   <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign evt_out  = evt_q;
  assign busy_out = busy_q;
  assign done_out = done_q;
  assign sent_out = sent_q;

endmodule

// File: tb/tb_evt_burst_gen.sv
// Bench for evt_burst_gen: schedule-based reference model checked every
// cycle, plus literal pulse/done offsets per directed burst.
module tb_evt_burst_gen;

  localparam int unsigned CW = 16;
  localparam int unsigned GW = 8;

  logic          clk;
  logic          rst;
  logic          start_in;
  logic [CW-1:0] num_in;
  logic [GW-1:0] gap_in;
  logic          abort_in;
  logic          evt_out;
  logic          busy_out;
  logic          done_out;
  logic [CW-1:0] sent_out;

  evt_burst_gen #(.COUNT_W(CW), .GAP_W(GW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_in (start_in),
    .num_in   (num_in),
    .gap_in   (gap_in),
    .abort_in (abort_in),
    .evt_out  (evt_out),
    .busy_out (busy_out),
    .done_out (done_out),
    .sent_out (sent_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a burst is a schedule of cycles 1..end relative to the
  // accepting edge. Pulses fall on cycles 1, 1+P, 1+2P, ... (P = gap+1) before
  // end; done is the end cycle. Abort pulls end in to the following cycle.
  int            m_rel = 0;
  int            m_end = 0;
  int            m_n   = 0;
  int            m_g   = 1;
  bit            m_act = 1'b0;
  logic          exp_evt  = 1'b0;
  logic          exp_busy = 1'b0;
  logic          exp_done = 1'b0;
  logic [CW-1:0] exp_sent = '0;
  int            cyc_p  = 0;
  int            lb_cnt = 0;

  always @(posedge clk) begin
    cyc_p = cyc_p + 1;
    if (!rst) begin
      m_act    = 1'b0;
      exp_evt  = 1'b0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_sent = '0;
      lb_cnt   = 0;
    end else begin
      if (evt_out) lb_cnt = lb_cnt + 1;
      if (exp_evt) exp_sent = exp_sent + 16'd1;
      if (!m_act) begin
        if (start_in) begin
          m_act    = 1'b1;
          m_n      = int'(num_in);
          m_g      = (gap_in == 0) ? 1 : int'(gap_in);
          exp_sent = '0;
          m_rel    = 0;
          m_end    = (m_n == 0) ? 1 : m_n + (m_n - 1) * m_g + 1;
        end
      end else if (m_rel == m_end) begin
        m_act = 1'b0;
      end else if (abort_in) begin
        m_end = m_rel + 1;
      end
      if (m_act) m_rel = m_rel + 1;
      exp_evt  = m_act && (m_rel < m_end) && (((m_rel - 1) % (m_g + 1)) == 0);
      exp_busy = m_act && (m_rel < m_end);
      exp_done = m_act && (m_rel == m_end);
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int off      = 0;
  int done_off = -1;
  int n_done   = 0;
  logic prev_evt = 1'b0;
  int pulses[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one cycle: sample at negedge, compare against model, log events.
  task automatic tick();
    @(negedge clk);
    off = off + 1;
    if (cyc_p > 0) begin
      chk("model_evt",  longint'(evt_out),  longint'(exp_evt));
      chk("model_busy", longint'(busy_out), longint'(exp_busy));
      chk("model_done", longint'(done_out), longint'(exp_done));
      chk("model_sent", longint'(sent_out), longint'(exp_sent));
    end
    if (evt_out) begin
      pulses.push_back(off);
      if (prev_evt) chk("evt_back_to_back", 1, 0);
    end
    prev_evt = evt_out;
    if (done_out) begin
      done_off = off;
      n_done   = n_done + 1;
    end
  endtask

  task automatic start_burst(input int n, input int g, input logic ab);
    num_in   = CW'(n);
    gap_in   = GW'(g);
    abort_in = ab;
    start_in = 1'b1;
    off      = 0;
    done_off = -1;
    pulses.delete();
    tick();
    start_in = 1'b0;
    abort_in = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int k;
    k = 0;
    while (done_off < 0 && k < lim) begin
      tick();
      k = k + 1;
    end
    if (done_off < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_pulses(input string name, input int exp[]);
    chk({name, "_npulses"}, pulses.size(), exp.size());
    for (int i = 0; i < exp.size() && i < pulses.size(); i++)
      chk({name, "_pulse_off"}, pulses[i], exp[i]);
  endtask

  initial begin
    int nd;
    int base;
    rst      = 1'b0;
    start_in = 1'b0;
    abort_in = 1'b0;
    num_in   = '0;
    gap_in   = '0;
    repeat (3) tick();
    chk("reset_evt",  longint'(evt_out),  0);
    chk("reset_busy", longint'(busy_out), 0);
    chk("reset_done", longint'(done_out), 0);
    chk("reset_sent", longint'(sent_out), 0);
    rst = 1'b1;
    repeat (2) tick();

    // Basic burst: 3 pulses, gap 2.
    start_burst(3, 2, 1'b0);
    wait_done(100);
    chk_pulses("basic", '{1, 4, 7});
    chk("basic_done_off", done_off, 8);
    chk("basic_sent", longint'(sent_out), 3);
    repeat (2) tick();

    // Zero gap is treated as one.
    start_burst(4, 0, 1'b0);
    wait_done(100);
    chk_pulses("gap0", '{1, 3, 5, 7});
    chk("gap0_done_off", done_off, 8);
    chk("gap0_sent", longint'(sent_out), 4);
    repeat (2) tick();

    // Empty burst.
    start_burst(0, 5, 1'b0);
    wait_done(10);
    chk("num0_done_off", done_off, 1);
    chk("num0_npulses", pulses.size(), 0);
    chk("num0_sent", longint'(sent_out), 0);
    repeat (2) tick();

    // Abort during the gap after the second pulse.
    start_burst(10, 4, 1'b0);
    repeat (7) tick();
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
    wait_done(10);
    repeat (6) tick();
    chk_pulses("abort", '{1, 6});
    chk("abort_done_off", done_off, 9);
    chk("abort_sent", longint'(sent_out), 2);

    // Start and abort together in IDLE: start wins.
    start_burst(2, 1, 1'b1);
    wait_done(20);
    chk_pulses("start_abort", '{1, 3});
    chk("start_abort_done_off", done_off, 4);
    repeat (2) tick();

    // Reset mid-burst abandons it without done.
    start_burst(5, 3, 1'b0);
    repeat (5) tick();
    nd  = n_done;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    chk("midrst_evt",  longint'(evt_out),  0);
    chk("midrst_busy", longint'(busy_out), 0);
    chk("midrst_done", longint'(done_out), 0);
    chk("midrst_sent", longint'(sent_out), 0);
    repeat (30) tick();
    chk("midrst_no_done", n_done, nd);

    // Loopback into a counter, with a stray start mid-burst.
    base = lb_cnt;
    start_burst(200, 1, 1'b0);
    repeat (50) tick();
    num_in   = CW'(7);
    gap_in   = GW'(9);
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    wait_done(1000);
    chk("loop_count", lb_cnt - base, 200);
    chk("loop_sent", longint'(sent_out), 200);
    chk("loop_done_off", done_off, 400);
    chk("loop_npulses", pulses.size(), 200);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
